reg_file_arbiter: RTL and testbench

REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

---
 rtl/reg_file_arbiter.sv | 104 ++++++++++
 tb/tb_reg_file_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_arbiter.sv
// Two-requester arbiter that time-shares a 4-entry register file port.
// Each ACCESS cycle serves one operation; the current owner is masked so back-to-back grants alternate.
module reg_file_arbiter (
  input  logic       clk,
  input  logic       Reset,
  input  logic       ReqA,
  input  logic       ReqB,
  input  logic       WeA,
  input  logic       WeB,
  input  logic [1:0] AddrA,
  input  logic [1:0] AddrB,
  input  logic [7:0] WDataA,
  input  logic [7:0] WDataB,
  input  logic [7:0] RegRData,
  output logic [3:0] RegNum,
  output logic       RegCE,
  output logic [7:0] RegWData,
  output logic       GntA,
  output logic       GntB,
  output logic       RValidA,
  output logic       RValidB,
  output logic [7:0] RData
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 0 = A, 1 = B
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rvalid_a_q, rvalid_a_d;
  logic        rvalid_b_q, rvalid_b_d;
  logic [7:0]  rdata_q, rdata_d;

  logic access;
  logic req_a_eff, req_b_eff;
  logic win, win_b;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;

    access    = (state_q == ACCESS);
    req_a_eff = ReqA & ~(access & ~owner_q);
    req_b_eff = ReqB & ~(access & owner_q);
    win       = req_a_eff | req_b_eff;
    // On a tie the requester that did not own the port last time wins.
    win_b     = req_b_eff & (~req_a_eff | ~last_q);

    state_d = win ? ACCESS : IDLE;
    if (win) begin
      owner_d = win_b;
      last_d  = win_b;
      we_d    = win_b ? WeB    : WeA;
      addr_d  = win_b ? AddrB  : AddrA;
      wdata_d = win_b ? WDataB : WDataA;
    end

    rvalid_a_d = access & ~we_q & ~owner_q;
    rvalid_b_d = access & ~we_q & owner_q;
    if (access && !we_q) rdata_d = RegRData;

    RegNum   = access ? (4'b0001 << addr_q) : 4'b0000;
    RegCE    = access & we_q & ~Reset;
    RegWData = wdata_q;
    GntA     = access & ~owner_q;
    GntB     = access & owner_q;
    RValidA  = rvalid_a_q;
    RValidB  = rvalid_b_q;
    RData    = rdata_q;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= 2'd0;
      wdata_q    <= 8'h00;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed bench for reg_file_arbiter with a behavioural 4x8 register file attached.
module tb_reg_file_arbiter;

  logic       clk = 1'b0;
  logic       Reset;
  logic       ReqA, ReqB, WeA, WeB;
  logic [1:0] AddrA, AddrB;
  logic [7:0] WDataA, WDataB;
  logic [7:0] RegRData;
  logic [3:0] RegNum;
  logic       RegCE;
  logic [7:0] RegWData;
  logic       GntA, GntB, RValidA, RValidB;
  logic [7:0] RData;

  logic [7:0] regs [4];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_arbiter dut (
    .clk(clk), .Reset(Reset),
    .ReqA(ReqA), .ReqB(ReqB), .WeA(WeA), .WeB(WeB),
    .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
    .RegRData(RegRData), .RegNum(RegNum), .RegCE(RegCE), .RegWData(RegWData),
    .GntA(GntA), .GntB(GntB), .RValidA(RValidA), .RValidB(RValidB), .RData(RData)
  );

  always @(posedge clk) begin
    if (RegCE) begin
      for (int i = 0; i < 4; i++) if (RegNum[i]) regs[i] <= RegWData;
    end
  end

  always_comb begin
    RegRData = 8'h00;
    for (int i = 0; i < 4; i++) if (RegNum[i]) RegRData = regs[i];
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    // intentionally unused: each scenario checks inline
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    ReqA = 0; ReqB = 0; WeA = 0; WeB = 0;
    AddrA = 0; AddrB = 0; WDataA = 0; WDataB = 0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({RegNum, RegCE, GntA, GntB, RValidA, RValidB} !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000000", {RegNum, RegCE, GntA, GntB, RValidA, RValidB});
    end
    n_checks++;
    if ({RegWData, RData} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data: got %h want 0000", {RegWData, RData});
    end
  endtask

  task automatic test_write_then_read();
    ReqA = 1; WeA = 1; AddrA = 2; WDataA = 8'h5A;
    @(negedge clk);
    n_checks++;
    if ({GntA, GntB, RegNum, RegCE, RegWData} !== {1'b1, 1'b0, 4'b0100, 1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL wr_access: got gA=%b gB=%b num=%b ce=%b wd=%h want 1 0 0100 1 5a", GntA, GntB, RegNum, RegCE, RegWData);
    end
    ReqA = 0;
    @(negedge clk);
    n_checks++;
    if ({GntA, RegNum, RegCE, RegWData} !== {1'b0, 4'b0000, 1'b0, 8'h5A}) begin
      n_fail++; $display("FAIL wr_idle: got gA=%b num=%b ce=%b wd=%h want 0 0000 0 5a", GntA, RegNum, RegCE, RegWData);
    end
    ReqB = 1; WeB = 0; AddrB = 2;
    @(negedge clk);
    n_checks++;
    if ({GntA, GntB, RegNum, RegCE} !== {1'b0, 1'b1, 4'b0100, 1'b0}) begin
      n_fail++; $display("FAIL rd_access: got gA=%b gB=%b num=%b ce=%b want 0 1 0100 0", GntA, GntB, RegNum, RegCE);
    end
    ReqB = 0;
    @(negedge clk);
    n_checks++;
    if ({RValidA, RValidB, RData, GntB} !== {1'b0, 1'b1, 8'h5A, 1'b0}) begin
      n_fail++; $display("FAIL rd_valid: got vA=%b vB=%b rdata=%h gB=%b want 0 1 5a 0", RValidA, RValidB, RData, GntB);
    end
    @(negedge clk);
    n_checks++;
    if ({RValidB, RData} !== {1'b0, 8'h5A}) begin
      n_fail++; $display("FAIL rd_hold: got vB=%b rdata=%h want 0 5a", RValidB, RData);
    end
  endtask

  task automatic test_tie();
    do_reset();
    ReqA = 1; WeA = 1; AddrA = 0; WDataA = 8'h11;
    ReqB = 1; WeB = 1; AddrB = 1; WDataB = 8'h22;
    @(negedge clk);
    n_checks++;
    if ({GntA, GntB, RegNum, RegWData} !== {1'b1, 1'b0, 4'b0001, 8'h11}) begin
      n_fail++; $display("FAIL tie_first: got gA=%b gB=%b num=%b wd=%h want 1 0 0001 11", GntA, GntB, RegNum, RegWData);
    end
    ReqA = 0;
    @(negedge clk);
    n_checks++;
    if ({GntA, GntB, RegNum, RegCE, RegWData} !== {1'b0, 1'b1, 4'b0010, 1'b1, 8'h22}) begin
      n_fail++; $display("FAIL tie_second: got gA=%b gB=%b num=%b ce=%b wd=%h want 0 1 0010 1 22", GntA, GntB, RegNum, RegCE, RegWData);
    end
    ReqB = 0;
    @(negedge clk);
    ReqA = 1; WeA = 0; AddrA = 0;
    ReqB = 1; WeB = 0; AddrB = 1;
    @(negedge clk);
    n_checks++;
    if ({GntA, GntB} !== 2'b10) begin
      n_fail++; $display("FAIL tie_rd_gnt_a: got gA=%b gB=%b want 1 0", GntA, GntB);
    end
    ReqA = 0;
    @(negedge clk);
    n_checks++;
    if ({GntB, RValidA, RValidB, RData} !== {1'b1, 1'b1, 1'b0, 8'h11}) begin
      n_fail++; $display("FAIL tie_rd_a: got gB=%b vA=%b vB=%b rdata=%h want 1 1 0 11", GntB, RValidA, RValidB, RData);
    end
    ReqB = 0;
    @(negedge clk);
    n_checks++;
    if ({RValidA, RValidB, RData} !== {1'b0, 1'b1, 8'h22}) begin
      n_fail++; $display("FAIL tie_rd_b: got vA=%b vB=%b rdata=%h want 0 1 22", RValidA, RValidB, RData);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] da, db, last_a, last_b;
    logic exp_b;
    da = 8'hA0; db = 8'hB0; last_a = 8'h00; last_b = 8'h00;
    ReqA = 1; WeA = 1; AddrA = 0; WDataA = da;
    ReqB = 1; WeB = 1; AddrB = 1; WDataB = db;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_b = (k % 2) == 1;
      n_checks++;
      if ({GntA, GntB, RegWData} !== {~exp_b, exp_b, (exp_b ? db : da)}) begin
        n_fail++; $display("FAIL b2b_cycle%0d: got gA=%b gB=%b wd=%h want %b %b %h", k, GntA, GntB, RegWData, ~exp_b, exp_b, exp_b ? db : da);
      end
      if (exp_b) last_b = db; else last_a = da;
      if (k == 5) begin
        ReqA = 0; ReqB = 0;
      end else if (exp_b) begin
        db = db + 8'h01; WDataB = db;
      end else begin
        da = da + 8'h01; WDataA = da;
      end
    end
    @(negedge clk);
    n_checks++;
    if ({regs[0], regs[1]} !== {last_a, last_b}) begin
      n_fail++; $display("FAIL b2b_regs: got %h %h want %h %h", regs[0], regs[1], last_a, last_b);
    end
    // Read followed by write to the same register returns the old value.
    ReqA = 1; WeA = 0; AddrA = 1;
    ReqB = 1; WeB = 1; AddrB = 1; WDataB = 8'h77;
    @(negedge clk);
    ReqA = 0;
    @(negedge clk);
    ReqB = 0;
    n_checks++;
    if ({GntB, RValidA, RData} !== {1'b1, 1'b1, last_b}) begin
      n_fail++; $display("FAIL rd_before_wr: got gB=%b vA=%b rdata=%h want 1 1 %h", GntB, RValidA, RData, last_b);
    end
    @(negedge clk);
    n_checks++;
    if (regs[1] !== 8'h77) begin
      n_fail++; $display("FAIL wr_after_rd: got %h want 77", regs[1]);
    end
  endtask

  task automatic test_reset_during_access();
    do_reset();
    ReqA = 1; WeA = 1; AddrA = 3; WDataA = 8'hFF;
    @(negedge clk);
    ReqA = 0;
    @(negedge clk);
    ReqA = 1; WeA = 1; AddrA = 3; WDataA = 8'h00;
    @(negedge clk);
    n_checks++;
    if ({GntA, RegCE, RegNum} !== {1'b1, 1'b1, 4'b1000}) begin
      n_fail++; $display("FAIL rst_pre: got gA=%b ce=%b num=%b want 1 1 1000", GntA, RegCE, RegNum);
    end
    Reset = 1; ReqA = 0; ReqB = 1; WeB = 1; AddrB = 3; WDataB = 8'h33;
    #1;
    n_checks++;
    if (RegCE !== 1'b0) begin
      n_fail++; $display("FAIL rst_ce: got %b want 0", RegCE);
    end
    @(negedge clk);
    Reset = 0; ReqB = 0;
    n_checks++;
    if ({RegNum, RegCE, GntA, GntB, RValidA, RValidB, RegWData, RData} !== {9'b0, 16'h0000}) begin
      n_fail++; $display("FAIL rst_outputs: got num=%b ce=%b g=%b%b v=%b%b wd=%h rd=%h want all zero", RegNum, RegCE, GntA, GntB, RValidA, RValidB, RegWData, RData);
    end
    n_checks++;
    if (regs[3] !== 8'hFF) begin
      n_fail++; $display("FAIL rst_dropped_write: got %h want ff", regs[3]);
    end
    @(negedge clk);
    n_checks++;
    if ({GntA, GntB, RValidA, RValidB} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_no_pending: got g=%b%b v=%b%b want 0000", GntA, GntB, RValidA, RValidB);
    end
    ReqB = 1; WeB = 0; AddrB = 3;
    @(negedge clk);
    ReqB = 0;
    @(negedge clk);
    n_checks++;
    if ({RValidB, RData} !== {1'b1, 8'hFF}) begin
      n_fail++; $display("FAIL rst_readback: got vB=%b rdata=%h want 1 ff", RValidB, RData);
    end
  endtask

  always @(negedge clk) begin
    if (!Reset && ((GntA && GntB) || (RValidA && RValidB))) begin
      n_checks++;
      n_fail++;
      $display("FAIL exclusive: gA=%b gB=%b vA=%b vB=%b", GntA, GntB, RValidA, RValidB);
    end
  end

  initial begin
    test_reset();
    test_write_then_read();
    test_tie();
    test_back_to_back();
    test_reset_during_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
